// File: rtl/rv32i_types.sv
// Shared types for the rv32i pipeline: branch predictor counter encoding.
// Holds the gshare default history width and the counter step helper.
package rv32i_types;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } pred_counter_t;

    localparam int GSHARE_HISTORY_BITS = 8;

    function automatic pred_counter_t sat_step(
        input pred_counter_t c,
        input logic          taken
    );
        pred_counter_t n;
        case (c)
            SNT: n = taken ? WNT : SNT;
            WNT: n = taken ? WT  : SNT;
            WT:  n = taken ? ST  : WNT;
            ST:  n = taken ? ST  : WT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table: 2^HISTORY_BITS saturating 2-bit counters.
// One combinational read port, one saturating train port.
module gshare_pht
    import rv32i_types::*;
#(
    parameter int HISTORY_BITS = GSHARE_HISTORY_BITS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [HISTORY_BITS-1:0] rd_index,
    output pred_counter_t           rd_counter,
    input  logic                    wr_en,
    input  logic [HISTORY_BITS-1:0] wr_index,
    input  logic                    wr_taken
);

    localparam int ENTRIES = 1 << HISTORY_BITS;

    pred_counter_t pht [ENTRIES];

    // Read is pre-update: a same-cycle train is visible next cycle.
    assign rd_counter = pht[rd_index];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht[i] <= WNT;
            end
        end else if (wr_en) begin
            pht[wr_index] <= sat_step(pht[wr_index], wr_taken);
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PHT indexed by fetch PC XOR global history.
// Define GSHARE_SPEC_HISTORY_EN for speculative history with mispredict repair.
module gshare_predictor
    import rv32i_types::*;
#(
    parameter int HISTORY_BITS = GSHARE_HISTORY_BITS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             IF_pc,
    input  logic                    IF_is_branch,
    output logic                    global_prediction,
    output logic [HISTORY_BITS-1:0] IF_index,
    input  logic [HISTORY_BITS-1:0] MEM_index,
    input  logic                    branch_result,
    input  logic                    update,
    input  logic                    mispredict
);

    logic [HISTORY_BITS-1:0] ghr_ret;
    logic [HISTORY_BITS-1:0] lookup_ghr;
    pred_counter_t           rd_counter;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_ret <= '0;
        end else if (update) begin
            ghr_ret <= {ghr_ret[HISTORY_BITS-2:0], branch_result};
        end
    end

`ifdef GSHARE_SPEC_HISTORY_EN
    logic [HISTORY_BITS-1:0] ghr_spec;

    // Repair wins over a same-cycle fetch shift, which is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_spec <= '0;
        end else if (update && mispredict) begin
            ghr_spec <= {ghr_ret[HISTORY_BITS-2:0], branch_result};
        end else if (IF_is_branch) begin
            ghr_spec <= {ghr_spec[HISTORY_BITS-2:0], global_prediction};
        end
    end

    assign lookup_ghr = ghr_spec;

    logic unused_pc;
    assign unused_pc = ^{IF_pc[31:HISTORY_BITS+2], IF_pc[1:0]};
`else
    assign lookup_ghr = ghr_ret;

    logic unused_pc;
    assign unused_pc = ^{IF_pc[31:HISTORY_BITS+2], IF_pc[1:0],
                         IF_is_branch, mispredict};
`endif

    assign IF_index = IF_pc[HISTORY_BITS+1:2] ^ lookup_ghr;

    gshare_pht #(
        .HISTORY_BITS(HISTORY_BITS)
    ) u_pht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_index  (IF_index),
        .rd_counter(rd_counter),
        .wr_en     (update),
        .wr_index  (MEM_index),
        .wr_taken  (branch_result)
    );

    assign global_prediction = rd_counter[1];

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Global-history (gshare) direction predictor in the IF stage. It produces the `global_prediction` bit that the tournament predictor arbitrates against the local predictor. It indexes a pattern history table (PHT) of 2-bit saturating counters with the IF PC XOR a global history register (GHR). It trains from resolved branches in MEM and, optionally, keeps a speculative history with recovery on mispredict.

## Interface

Parameters:
- `HISTORY_BITS`, default 8: GHR width; the PHT has 2^HISTORY_BITS entries.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `IF_pc` input 32: fetch PC.
- `IF_is_branch` input 1: the IF instruction is a conditional branch that hit in the BTB. Used only with speculation.
- `global_prediction` output 1: 1 = predict taken.
- `IF_index` output HISTORY_BITS: PHT index used for this lookup; the pipeline carries it to MEM.
- `MEM_index` input HISTORY_BITS: carried index of the resolving branch.
- `branch_result` input 1: actual outcome, 1 = taken.
- `update` input 1: a conditional branch resolves in MEM this cycle.
- `mispredict` input 1: the final prediction for the resolving branch was wrong. It is valid only with `update`.

## Operation

- Index: `IF_index = IF_pc[HISTORY_BITS+1:2] ^ lookup_ghr`. `lookup_ghr` is the speculative GHR when the macro is defined, otherwise the retired GHR.
- Lookup: combinational. `global_prediction = PHT[IF_index][1]`.
- Counter encoding: 0 strongly-NT, 1 weakly-NT, 2 weakly-T, 3 strongly-T.
- Training when `update` is high, at the clock edge:
  - `PHT[MEM_index]` increments if `branch_result` is 1 and decrements if 0.
  - The counter saturates at 3 and at 0.
  - No other entry changes.
- Retired GHR: on `update`, `ghr_ret <= {ghr_ret[HISTORY_BITS-2:0], branch_result}`. The newest outcome goes into bit 0.
- Same-cycle read and write of the same entry: the read returns the pre-update value. There is no bypass.
- Reset: every PHT entry is set to 1 (weakly-NT) and every GHR is set to 0. `global_prediction` is 0 during reset. `IF_index` equals `IF_pc[HISTORY_BITS+1:2]` during reset.
- Reset asserted mid-operation discards all training immediately and asynchronously. The first edge after release behaves as a post-reset cycle.

## Timing

- Lookup latency: 0 cycles (same cycle as `IF_pc`).
- Training latency: 1 cycle. A lookup in the cycle after `update` sees the new counter value and the new retired GHR.
- `update` with no `mispredict` and `update` with `mispredict` train identically. `mispredict` affects only speculative history.
- `mispredict` without `update` is ignored.

## Configuration

- `GSHARE_SPEC_HISTORY_EN` defined:
  - A speculative GHR `ghr_spec` is used for lookup.
  - On `IF_is_branch`, it shifts in `global_prediction`.
  - On `update && mispredict`, `ghr_spec <= {ghr_ret[HISTORY_BITS-2:0], branch_result}`. This is the corrected retired history.
  - The recovery takes priority over a same-cycle IF shift, which is dropped.
  - `ghr_spec` resets to 0.
- `GSHARE_SPEC_HISTORY_EN` not defined:
  - There is no speculative register.
  - Lookup uses `ghr_ret`.
  - `IF_is_branch` and `mispredict` are unused.

## Structure

Shared package `rv32i_types`:
- enum `pred_counter_t` {SNT=2'd0, WNT=2'd1, WT=2'd2, ST=2'd3}.
- constant `GSHARE_HISTORY_BITS = 8`, used as the default by the top level.

Sub-module `gshare_pht`:
- 2^HISTORY_BITS flop array of `pred_counter_t` with async reset to WNT.
- One combinational read port.
- One saturating increment/decrement write port.

Top level `gshare_predictor`:
- Holds the GHR(s), the index XOR and the optional speculative logic.

## Test plan

1. Reset with `IF_pc=0x40` → `global_prediction=0`, `IF_index=0x10`. All 256 entries read WNT.
2. Saturation, with HISTORY_BITS=8: hold `MEM_index=0x05` and pulse `update` with `branch_result=1` four times.
   - Required counter sequence: 1→2→3→3.
   - A lookup resolving to index 0x05 predicts 1 after the first pulse.
   - Four pulses with `branch_result=0` then give 3→2→1→0.
3. Retired history: GHR=0, then updates with outcomes 1,1,0 → GHR=0x06. Then `IF_pc=0x0000_0018` (bits[9:2]=0x06) → `IF_index=0x00`.
4. Same-cycle read and write: `IF_index` and `MEM_index` both 0x05, counter at 1, `update` taken.
   - Required: `global_prediction=0` that cycle, and 1 the next cycle.
5. With `GSHARE_SPEC_HISTORY_EN`: three `IF_is_branch` with prediction 0, then `update`+`mispredict` with `branch_result=1` and `ghr_ret=0x03` in the same cycle as an `IF_is_branch`.
   - Required: `ghr_spec=0x07` next cycle, and the IF shift is dropped.
6. Reset mid-operation: train entry 0x05 to 3, then assert `rst_n=0` between clock edges.
   - Required: entry 0x05 reads 1 immediately, without waiting for a clock edge.
   - The GHR(s) read 0 and `global_prediction=0`.
